conv_layer_scheduler: RTL and testbench

- Sequences one convolution layer through the multi-input-channel convolution datapath (per-input-channel convolution units feeding an adder tree).
- For each output-channel group it:
  - loads conv_size×conv_size weight words from an upstream weight stream into the datapath;
  - opens the window stream;
  - counts adder-tree results until the feature map is complete;
  - advances to the next group.
- Sits between the layer control registers/DMA and the convolution output-channel datapath.

---
 rtl/conv_layer_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_scheduler
// Purpose  : Sequences one convolution layer through the multi-input-channel
//            convolution datapath. For each output-channel group it loads
//            conv_size^2 weight words, opens the window stream, counts
//            adder-tree results until the feature map is complete, then moves
//            on to the next group.
// Ports    :
//   clk, reset              - clock, asynchronous active-low reset
//   start_in                - one-cycle layer start pulse (honoured in IDLE)
//   max_cols_in/max_rows_in - feature-map geometry
//   conv_size_in            - kernel dimension (1..CONV_KERNEL_DIM)
//   num_groups_in           - number of output-channel groups (>= 1)
//   wt_data_in/wt_valid_in/wt_ready_out - upstream weight stream
//   weights_out/weights_valid_out       - registered weight word to datapath
//   win_enable_out          - permits the window generator to issue windows
//   conv_result_valid_in    - adder-tree result strobe from datapath
//   group_idx_out           - current output-channel group
//   busy_out/done_out/err_out - layer status
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_scheduler #(
  parameter int DATA_WIDTH      = 16,
  parameter int INPUT_DIM       = 4,
  parameter int DIM_WIDTH       = 10,
  parameter int CONV_KERNEL_DIM = 3,
  parameter int GRP_WIDTH       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_in,
  input  logic [DIM_WIDTH-1:0]            max_cols_in,
  input  logic [DIM_WIDTH-1:0]            max_rows_in,
  input  logic [DIM_WIDTH-1:0]            conv_size_in,
  input  logic [GRP_WIDTH-1:0]            num_groups_in,
  input  logic [INPUT_DIM*DATA_WIDTH-1:0] wt_data_in,
  input  logic                            wt_valid_in,
  output logic                            wt_ready_out,
  output logic [INPUT_DIM*DATA_WIDTH-1:0] weights_out,
  output logic                            weights_valid_out,
  output logic                            win_enable_out,
  input  logic                            conv_result_valid_in,
  output logic [GRP_WIDTH-1:0]            group_idx_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            err_out
);

  // Counters are wide enough for rows*cols without truncation.
  localparam int                   c_cnt_w = 2 * DIM_WIDTH;
  localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);
  localparam logic [DIM_WIDTH-1:0] c_max_k   = DIM_WIDTH'(CONV_KERNEL_DIM);
  localparam logic [GRP_WIDTH-1:0] c_grp_one = GRP_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_WT = 3'd1,
    S_STREAM  = 3'd2,
    S_NEXT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;

  logic [c_cnt_w-1:0]              r_wt_total;
  logic [c_cnt_w-1:0]              r_px_total;
  logic [c_cnt_w-1:0]              r_wt_cnt;
  logic [c_cnt_w-1:0]              r_px_cnt;
  logic [GRP_WIDTH-1:0]            r_num_groups;
  logic [GRP_WIDTH-1:0]            r_group_idx;
  logic [INPUT_DIM*DATA_WIDTH-1:0] r_weights;
  logic                            r_weights_valid;
  logic                            r_err;

  logic                            w_cfg_ok;
  logic                            w_start;
  logic                            w_wt_hs;
  logic                            w_res_ok;
  logic                            w_res_bad;
  logic                            w_wt_last;
  logic                            w_px_last;
  logic                            w_grp_last;
  logic [c_cnt_w-1:0]              w_wt_total_calc;
  logic [c_cnt_w-1:0]              w_px_total_calc;

  logic                            w_wt_ready;
  logic                            w_win_enable;
  logic                            w_busy;
  logic                            w_done;

  // --------------------------------------------------------------------------
  // Configuration decode
  // --------------------------------------------------------------------------
  assign w_cfg_ok = (conv_size_in != '0) && (conv_size_in <= c_max_k) &&
                    (max_rows_in != '0) && (max_cols_in != '0) &&
                    (num_groups_in != '0);

  assign w_wt_total_calc = c_cnt_w'(conv_size_in) * c_cnt_w'(conv_size_in);
  assign w_px_total_calc = c_cnt_w'(max_rows_in) * c_cnt_w'(max_cols_in);

  assign w_start    = start_in && (r_state == S_IDLE);
  assign w_wt_hs    = wt_valid_in && (r_state == S_LOAD_WT);
  assign w_res_ok   = conv_result_valid_in && (r_state == S_STREAM);
  // A result strobe outside the streaming window is a datapath protocol fault.
  assign w_res_bad  = conv_result_valid_in && (r_state != S_STREAM);
  assign w_wt_last  = (r_wt_cnt == (r_wt_total - c_cnt_one));
  assign w_px_last  = (r_px_cnt == (r_px_total - c_cnt_one));
  assign w_grp_last = (r_group_idx == (r_num_groups - c_grp_one));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_wt_ready   = 1'b0;
    w_win_enable = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start_in) begin
          w_state_next = w_cfg_ok ? S_LOAD_WT : S_DONE;
        end
      end
      S_LOAD_WT: begin
        // Ready is decoded from state, so it falls in the same cycle the FSM
        // leaves LOAD_WT and no word beyond the last one is accepted.
        w_wt_ready = 1'b1;
        if (wt_valid_in && w_wt_last) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        w_win_enable = 1'b1;
        if (conv_result_valid_in && w_px_last) begin
          w_state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        w_state_next = w_grp_last ? S_DONE : S_LOAD_WT;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, configuration and registered weight path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wt_total      <= '0;
      r_px_total      <= '0;
      r_wt_cnt        <= '0;
      r_px_cnt        <= '0;
      r_num_groups    <= '0;
      r_group_idx     <= '0;
      r_weights       <= '0;
      r_weights_valid <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_weights_valid <= w_wt_hs;
      if (w_wt_hs) begin
        r_weights <= wt_data_in;
      end

      if (w_start) begin
        r_wt_total   <= w_wt_total_calc;
        r_px_total   <= w_px_total_calc;
        r_num_groups <= num_groups_in;
        r_wt_cnt     <= '0;
        r_px_cnt     <= '0;
        r_group_idx  <= '0;
        r_err        <= !w_cfg_ok;
      end

      if (w_wt_hs) begin
        r_wt_cnt <= r_wt_cnt + c_cnt_one;
      end

      if (w_res_ok) begin
        r_px_cnt <= r_px_cnt + c_cnt_one;
      end

      if (r_state == S_NEXT) begin
        r_wt_cnt <= '0;
        r_px_cnt <= '0;
        if (!w_grp_last) begin
          r_group_idx <= r_group_idx + c_grp_one;
        end
      end

      // Placed last so a protocol fault is never masked by a clearing start.
      if (w_res_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wt_ready_out      = w_wt_ready;
  assign win_enable_out    = w_win_enable;
  assign busy_out          = w_busy;
  assign done_out          = w_done;
  assign weights_out       = r_weights;
  assign weights_valid_out = r_weights_valid;
  assign group_idx_out     = r_group_idx;
  assign err_out           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_scheduler
// Purpose  : Self-checking bench for conv_layer_scheduler. A table of layer
//            configurations plus randomized layers are driven; a transaction
//            model built from remaining-word / remaining-result counts
//            predicts every output each cycle, and per-layer totals are
//            checked against plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_scheduler;

  localparam int DATA_WIDTH      = 16;
  localparam int INPUT_DIM       = 4;
  localparam int DIM_WIDTH       = 10;
  localparam int CONV_KERNEL_DIM = 3;
  localparam int GRP_WIDTH       = 8;
  localparam int WW              = INPUT_DIM * DATA_WIDTH;
  localparam int BUDGET          = 5000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start_in = 1'b0;
  logic [DIM_WIDTH-1:0] max_cols_in = '0;
  logic [DIM_WIDTH-1:0] max_rows_in = '0;
  logic [DIM_WIDTH-1:0] conv_size_in = '0;
  logic [GRP_WIDTH-1:0] num_groups_in = '0;
  logic [WW-1:0]        wt_data_in = '0;
  logic                 wt_valid_in = 1'b0;
  logic                 wt_ready_out;
  logic [WW-1:0]        weights_out;
  logic                 weights_valid_out;
  logic                 win_enable_out;
  logic                 conv_result_valid_in = 1'b0;
  logic [GRP_WIDTH-1:0] group_idx_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 err_out;

  conv_layer_scheduler #(
    .DATA_WIDTH(DATA_WIDTH), .INPUT_DIM(INPUT_DIM), .DIM_WIDTH(DIM_WIDTH),
    .CONV_KERNEL_DIM(CONV_KERNEL_DIM), .GRP_WIDTH(GRP_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .start_in(start_in),
    .max_cols_in(max_cols_in), .max_rows_in(max_rows_in),
    .conv_size_in(conv_size_in), .num_groups_in(num_groups_in),
    .wt_data_in(wt_data_in), .wt_valid_in(wt_valid_in),
    .wt_ready_out(wt_ready_out), .weights_out(weights_out),
    .weights_valid_out(weights_valid_out), .win_enable_out(win_enable_out),
    .conv_result_valid_in(conv_result_valid_in), .group_idx_out(group_idx_out),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a layer is a number of words still to load and results
  // still to collect for the current group, followed by one bookkeeping cycle
  // and a one-cycle completion marker.
  // --------------------------------------------------------------------------
  bit          m_idle;
  int          m_load_left, m_res_left;
  bit          m_next, m_done;
  int          m_grp;
  bit          m_err;
  bit          m_wv;
  logic [WW-1:0] m_wd;
  int          m_k, m_rows, m_cols, m_groups;

  function automatic bit m_loading();  return !m_idle && m_load_left > 0; endfunction
  function automatic bit m_stream();   return !m_idle && m_load_left == 0 && m_res_left > 0; endfunction

  function automatic bit cfg_ok(input int k, input int rows, input int cols, input int groups);
    return (k >= 1) && (k <= CONV_KERNEL_DIM) && (rows != 0) && (cols != 0) && (groups != 0);
  endfunction

  task automatic model_reset();
    m_idle = 1; m_load_left = 0; m_res_left = 0; m_next = 0; m_done = 0;
    m_grp = 0; m_err = 0; m_wv = 0; m_wd = '0;
  endtask

  task automatic model_step(input bit st, input int cols, input int rows, input int k,
                            input int groups, input bit wv, input logic [WW-1:0] wd,
                            input bit rv);
    bit was_stream;
    was_stream = m_stream();
    m_wv = 0;
    if (m_idle) begin
      if (st) begin
        m_k = k; m_rows = rows; m_cols = cols; m_groups = groups;
        m_grp = 0; m_idle = 0;
        m_err = !cfg_ok(k, rows, cols, groups);
        if (cfg_ok(k, rows, cols, groups)) m_load_left = k * k;
        else m_done = 1;
      end
    end else if (m_load_left > 0) begin
      if (wv) begin
        m_wv = 1; m_wd = wd; m_load_left--;
        if (m_load_left == 0) m_res_left = m_rows * m_cols;
      end
    end else if (m_res_left > 0) begin
      if (rv) begin
        m_res_left--;
        if (m_res_left == 0) m_next = 1;
      end
    end else if (m_next) begin
      m_next = 0;
      if (m_grp == m_groups - 1) m_done = 1;
      else begin m_grp++; m_load_left = m_k * m_k; end
    end else if (m_done) begin
      m_done = 0; m_idle = 1;
    end
    if (rv && !was_stream) m_err = 1;
  endtask

  task automatic check_outputs();
    chk("wt_ready", WW'(wt_ready_out), WW'(m_loading()));
    chk("win_enable", WW'(win_enable_out), WW'(m_stream()));
    chk("busy", WW'(busy_out), WW'(!m_idle));
    chk("done", WW'(done_out), WW'(m_done));
    chk("group_idx", WW'(group_idx_out), WW'(m_grp));
    chk("err", WW'(err_out), WW'(m_err));
    chk("weights_valid", WW'(weights_valid_out), WW'(m_wv));
    if (m_wv) chk("weights_data", weights_out, m_wd);
  endtask

  task automatic check_all_zero();
    chk("rst_wt_ready", WW'(wt_ready_out), '0);
    chk("rst_win_enable", WW'(win_enable_out), '0);
    chk("rst_busy", WW'(busy_out), '0);
    chk("rst_done", WW'(done_out), '0);
    chk("rst_group_idx", WW'(group_idx_out), '0);
    chk("rst_err", WW'(err_out), '0);
    chk("rst_weights_valid", WW'(weights_valid_out), '0);
    chk("rst_weights", weights_out, '0);
  endtask

  // mode: 0 = back-to-back stream, start re-asserted on DONE cycle
  //       1 = weight valid every other cycle, results back-to-back
  //       2 = random gaps and random stray start pulses while busy
  typedef struct {
    int cols; int rows; int k; int groups; int mode;
    bit stray; bit abort; bit exp_err;
  } vec_t;

  task automatic run_layer(input vec_t v);
    int cyc, n_wv, n_done;
    bit st, wv, rv, stray_done;
    logic [WW-1:0] wd;
    cyc = 0; n_wv = 0; n_done = 0; stray_done = 0;
    max_cols_in   = DIM_WIDTH'(v.cols);
    max_rows_in   = DIM_WIDTH'(v.rows);
    conv_size_in  = DIM_WIDTH'(v.k);
    num_groups_in = GRP_WIDTH'(v.groups);
    forever begin
      @(negedge clk);
      check_outputs();
      if (weights_valid_out) n_wv++;
      if (done_out) n_done++;
      if (cyc > 0 && m_idle) break;
      if (cyc > BUDGET) begin
        chk("layer_timeout", WW'(cyc), WW'(BUDGET));
        break;
      end
      if (v.abort && m_stream() && m_grp == 1) begin
        start_in = 0; wt_valid_in = 0; conv_result_valid_in = 0;
        #2 reset = 1'b0;
        #1 check_all_zero();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (cyc == 0) st = 1;
      else if (v.mode == 0) st = m_done;
      else if (v.mode == 2) st = !m_idle && ($urandom_range(7) == 0);
      else st = 0;
      case (v.mode)
        0: wv = 1;
        1: wv = cyc[0];
        default: wv = $urandom_range(1) == 1;
      endcase
      wd = {$urandom, $urandom};
      rv = m_stream() && (v.mode != 2 || $urandom_range(1) == 1);
      if (v.stray && !stray_done && m_loading()) begin
        rv = 1; stray_done = 1;
      end
      start_in = st; wt_valid_in = wv; wt_data_in = wd; conv_result_valid_in = rv;
      model_step(st, v.cols, v.rows, v.k, v.groups, wv, wd, rv);
      cyc++;
    end
    start_in = 0; wt_valid_in = 0; conv_result_valid_in = 0;
    chk("done_pulses", WW'(n_done), WW'(1));
    chk("words_loaded", WW'(n_wv),
        WW'(cfg_ok(v.k, v.rows, v.cols, v.groups) ? v.k * v.k * v.groups : 0));
    chk("final_err", WW'(err_out), WW'(v.exp_err));
    if (cfg_ok(v.k, v.rows, v.cols, v.groups))
      chk("final_group", WW'(group_idx_out), WW'(v.groups - 1));
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4, 4, 3, 1, 0, 0, 0, 0};
    tbl[1]  = '{3, 2, 1, 3, 0, 0, 0, 0};
    tbl[2]  = '{4, 4, 3, 1, 1, 0, 0, 0};
    tbl[3]  = '{4, 4, 4, 1, 0, 0, 0, 1};
    tbl[4]  = '{4, 0, 3, 1, 0, 0, 0, 1};
    tbl[5]  = '{2, 3, 2, 1, 0, 0, 0, 0};
    tbl[6]  = '{3, 3, 2, 2, 2, 1, 0, 1};
    tbl[7]  = '{2, 2, 1, 3, 2, 0, 1, 0};
    tbl[8]  = '{2, 2, 1, 3, 2, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{3, 3, 0, 1, 0, 0, 0, 1};
    tbl[11] = '{0, 3, 2, 1, 0, 0, 0, 1};
    tbl[12] = '{3, 3, 2, 0, 0, 0, 0, 1};
    tbl[13] = '{5, 3, 3, 2, 1, 1, 0, 1};

    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run_layer(tbl[i]);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.cols = $urandom_range(6, 1);
      v.rows = $urandom_range(6, 1);
      v.k = $urandom_range(3, 1);
      v.groups = $urandom_range(3, 1);
      v.mode = 2; v.stray = 0; v.abort = 0; v.exp_err = 0;
      run_layer(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
